// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bus of one pipeline stage: upstream in_* beat, downstream out_* beat.
// master = the surrounding pipeline, slave = the stage register.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid, flush-to-bubble and registered in_ready.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_skid_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    if (CNT_W < 1 || CTRL_W < 1 || DATA_W < 1) begin : g_bad_width
        $error("pipe_stage_skid: widths must be >= 1");
    end

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid;
    logic              accept;
    logic              retire;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign retire    = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = BUSY;
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                end
            end
            BUSY: begin
                if (accept && retire) begin
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_ctrl_d = bus.in_ctrl;
                    skid_data_d = bus.in_data;
                end else if (retire) begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end
            end
            FULL: begin
                if (retire) begin
                    state_d     = BUSY;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end
        endcase
        // Flush leaves a bubble but keeps the last payload visible.
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = main_data_q;
            skid_ctrl_d = '0;
            skid_data_d = skid_data_q;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !bus.out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: in-order beat queue as reference,
// directed test-plan sequences followed by randomized traffic.
module tb_pipe_stage_skid;

    localparam int CW = 16;
    localparam int DW = 96;
`ifdef PIPE_STAGE_PERF_EN
    localparam int NW = 4;
`else
    localparam int NW = 32;
`endif

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;
`endif

    pipe_stage_skid #(
        .CTRL_W(CW),
        .DATA_W(DW),
        .CNT_W (NW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    beat_t         q[$];
    int            checks = 0;
    int            errors = 0;
    int            nret   = 0;
    bit            armed  = 0;
    logic [DW-1:0] last_shown = '0;
    int            stall_m  = 0;
    int            bubble_m = 0;
    localparam int SAT = (1 << NW) - 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, let the edge happen, then advance the model.
    task automatic step(input bit r, input bit f, input bit v,
                        input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy);
        bit acc;
        bit cur_valid;
        rst           = r;
        flush         = f;
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cur_valid     = (q.size() > 0);
        @(negedge clk);
        acc = v && (bus.in_ready === 1'b1) && !r && !f;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            stall_m  = 0;
            bubble_m = 0;
            armed    = 1;
        end else begin
            if (cur_valid && !ordy && stall_m < SAT) stall_m++;
            if (!cur_valid && bubble_m < SAT) bubble_m++;
            if (f) q.delete();
            else if (acc) q.push_back('{ctrl: c, data: d});
        end
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, ordy);
    endtask

    task automatic beat(input logic [CW-1:0] c, input bit ordy);
        step(0, 0, 1, c, {$urandom, $urandom, $urandom}, ordy);
    endtask

    // Monitor: compare what the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            last_shown <= '0;
        end else if (armed) begin
            chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
            chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
            chk("bubble_cnt", 128'(bubble_cnt), 128'(bubble_m));
`endif
            if (q.size() > 0) begin
                chk("out_ctrl", 128'(bus.out_ctrl), 128'(q[0].ctrl));
                chk("out_data", 128'(bus.out_data), 128'(q[0].data));
                last_shown <= q[0].data;
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    nret++;
                end
            end else begin
                chk("bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
                chk("bubble_data", 128'(bus.out_data), 128'(last_shown));
            end
        end
    end

    initial begin
        int n0;
        // Reset with a beat offered: must be ignored.
        step(1, 0, 1, 16'hFFFF, '1, 1);
        step(1, 0, 1, 16'hFFFF, '1, 1);
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset_out_data", 128'(bus.out_data), 128'(0));
        idle(1, 2);

        // Streaming, back-to-back.
        n0 = nret;
        for (int i = 1; i <= 5; i++) beat(CW'(i), 1);
        idle(1, 2);
        chk("stream_count", 128'(nret - n0), 128'(5));

        // Stall into the skid, then drain.
        n0 = nret;
        beat(16'h00A0, 0);
        beat(16'h00B0, 0);
        chk("skid_in_ready", 128'(bus.in_ready), 128'(0));
        idle(0, 2);
        idle(1, 3);
        chk("skid_count", 128'(nret - n0), 128'(2));

        // Flush while full, with a beat offered.
        n0 = nret;
        beat(16'h00A1, 0);
        beat(16'h00B1, 0);
        step(0, 1, 1, 16'h00C1, '1, 0);
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        idle(1, 3);
        chk("flush_count", 128'(nret - n0), 128'(0));

        // Reset and flush together while busy.
        beat(16'h0077, 0);
        step(1, 1, 0, '0, '0, 0);
        chk("rstflush_data", 128'(bus.out_data), 128'(0));
        idle(1, 2);

`ifdef PIPE_STAGE_PERF_EN
        step(1, 0, 0, '0, '0, 0);
        idle(0, 3);
        beat(16'h0055, 0);
        idle(0, 3);
        chk("perf_bubble4", 128'(bubble_cnt), 128'(4));
        chk("perf_stall3", 128'(stall_cnt), 128'(3));
        idle(0, 20);
        chk("perf_stall_sat", 128'(stall_cnt), 128'(SAT));
        idle(1, 20);
        chk("perf_bubble_sat", 128'(bubble_cnt), 128'(SAT));
        step(0, 1, 0, '0, '0, 1);
        chk("perf_flush_keep", 128'(bubble_cnt), 128'(SAT));
        step(1, 0, 0, '0, '0, 1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 CW'($urandom),
                 {$urandom, $urandom, $urandom},
                 ($urandom_range(0, 9) < 6));
        end
        idle(1, 4);
        chk("drain_empty", 128'(q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
